jpeg_idct_block_buf: RTL and testbench
======================================

JPEG_IDCT_BLOCK_BUF -- requirements
Module: jpeg_idct_block_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 6, meaning per-bank address width; bank depth is 2^ADDR_W words.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_i  input  1  write strobe.
REQ-006 SHALL have port wr_addr_i  input  ADDR_W  write address within the current write bank.
REQ-007 SHALL have port wr_data_i  input  WIDTH  write data.
REQ-008 SHALL have port wr_commit_i  input  1  marks the current write bank complete.
REQ-009 SHALL have port wr_ready_o  output  1  a free bank is available to write.
REQ-010 SHALL have port rd_i  input  1  read strobe.
REQ-011 SHALL have port rd_addr_i  input  ADDR_W  read address within the current read bank.
REQ-012 SHALL have port rd_release_i  input  1  frees the current read bank.
REQ-013 SHALL have port rd_valid_o  output  1  a committed bank is available to read.
REQ-014 SHALL have port rd_data_o  output  WIDTH  registered read data.
REQ-015 SHALL have port rd_data_valid_o  output  1  rd_data_o updated this cycle.
REQ-016 SHALL have port level_o  output  2  number of committed, unreleased banks (0..2).

Function
REQ-017 SHALL hold two banks of 2^ADDR_W x WIDTH, with a write-bank pointer, a read-bank pointer and a full count (0..2).
REQ-018 SHALL drive wr_ready_o = (count != 2), rd_valid_o = (count != 0) and level_o = count, all combinationally from registers.
REQ-019 SHALL write wr_data_i to wr_addr_i of the write bank when wr_i && wr_ready_o; wr_i SHALL be ignored while wr_ready_o is low.
REQ-020 SHALL accept wr_commit_i only when wr_ready_o: toggle the write pointer and increment count; wr_commit_i SHALL be ignored otherwise.
REQ-021 SHALL let wr_i and wr_commit_i in the same cycle write into the pre-toggle bank.
REQ-022 SHALL, on rd_i && rd_valid_o, present the addressed word of the read bank on rd_data_o one cycle later with rd_data_valid_o high for exactly that cycle.
REQ-023 SHALL ignore rd_i while rd_valid_o is low; rd_data_valid_o SHALL stay low and rd_data_o SHALL hold its value.
REQ-024 SHALL hold rd_data_o when rd_i is low.
REQ-025 SHALL accept rd_release_i only when rd_valid_o: toggle the read pointer and decrement count.
REQ-026 SHALL let rd_i and rd_release_i in the same cycle read from the pre-release bank.
REQ-027 SHALL, on simultaneous accepted commit and release, toggle both pointers and leave count unchanged.
REQ-028 SHALL never expose a bank being written to the reader; write and read banks differ whenever 0 < count < 2.

Reset
REQ-029 SHALL, while rst_i is low, force pointers to 0, count to 0, rd_data_o to 0 and rd_data_valid_o to 0.
REQ-030 SHALL not reset RAM contents; a reset mid-block discards all partial and committed banks.

Configuration
REQ-031 SHALL, with JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN defined, read at {rd_addr_i[ADDR_W/2-1:0], rd_addr_i[ADDR_W-1:ADDR_W/2]} (row/column swap); ADDR_W SHALL then be even.
REQ-032 SHALL, without JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN, use rd_addr_i unmodified.

Verification
REQ-033 SHALL cover: reset, write addr 0..63 data = addr, commit -> level_o=1, rd_valid_o=1; read addr 10 -> rd_data_o=10 one cycle later, rd_data_valid_o pulse.
REQ-034 SHALL cover: commit two banks (bank0 data 0x1xx, bank1 data 0x2xx) -> wr_ready_o=0; extra wr_i 0xFFFF to addr 0 ignored; read addr 0 -> 0x100; release -> read addr 0 -> 0x200.
REQ-035 SHALL cover: level_o=1 with simultaneous commit and release -> level_o stays 1, both pointers toggled.
REQ-036 SHALL cover: rd_i with rd_release_i same cycle at addr 5 -> data from released bank; rd_i at level 0 -> rd_data_valid_o=0, rd_data_o unchanged.
REQ-037 SHALL cover: TRANSPOSE_EN defined, write addr 0x0B (row1,col3) = 0xABCD, commit, read addr 0x19 -> 0xABCD.
REQ-038 SHALL cover: rst_i low after one commit and mid-write -> level_o=0, wr_ready_o=1, rd_valid_o=0, rd_data_o=0 asynchronously.

Source files
------------

// File: rtl/jpeg_idct_block_buf.sv
// jpeg_idct_block_buf: two-bank ping-pong block buffer between IDCT passes.
// Define JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN to read with row/column swapped.
module jpeg_idct_block_buf #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              wr_commit_i,
    output logic              wr_ready_o,
    input  logic              rd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_release_i,
    output logic              rd_valid_o,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_data_valid_o,
    output logic [1:0]        level_o
);

    logic [WIDTH-1:0]  mem [0:(1<<(ADDR_W+1))-1];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              wr_en;
    logic              rd_en;
    logic              commit_acc;
    logic              release_acc;
    logic [ADDR_W-1:0] rd_addr_eff;

    assign wr_ready_o  = (count != 2'd2);
    assign rd_valid_o  = (count != 2'd0);
    assign level_o     = count;

    assign wr_en       = wr_i && wr_ready_o;
    assign rd_en       = rd_i && rd_valid_o;
    assign commit_acc  = wr_commit_i && wr_ready_o;
    assign release_acc = rd_release_i && rd_valid_o;

`ifdef JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN
    localparam int HALF = ADDR_W / 2;
    assign rd_addr_eff = {rd_addr_i[HALF-1:0], rd_addr_i[ADDR_W-1:HALF]};
`else
    assign rd_addr_eff = rd_addr_i;
`endif

    // Bank pointers and committed-bank count; commit+release keeps count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (commit_acc)
                wr_ptr <= ~wr_ptr;
            if (release_acc)
                rd_ptr <= ~rd_ptr;
            unique case ({commit_acc, release_acc})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; a write uses the pre-commit bank pointer.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem[{wr_ptr, wr_addr_i}] <= wr_data_i;
    end

    // Registered read from the pre-release bank; data holds when idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_data_o       <= '0;
            rd_data_valid_o <= 1'b0;
        end else begin
            rd_data_valid_o <= rd_en;
            if (rd_en)
                rd_data_o <= mem[{rd_ptr, rd_addr_eff}];
        end
    end

endmodule

// File: tb/tb_jpeg_idct_block_buf.sv
// tb_jpeg_idct_block_buf: directed and random checks of the block buffer
// against a queue-of-blocks reference model.
module tb_jpeg_idct_block_buf;

    logic        clk;
    logic        rst;
    logic        wr;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_commit;
    logic        wr_ready;
    logic        rd;
    logic [5:0]  rd_addr;
    logic        rd_release;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_dv;
    logic [1:0]  level;

    int n_tests = 0;
    int n_fail  = 0;

    // model: block being written plus up to two committed blocks, oldest first
    logic [15:0] wdat [64];
    bit          wm   [64];
    logic [15:0] cdat [2][64];
    bit          cm   [2][64];
    int          ccnt;
    logic [15:0] exp_rd;
    bit          exp_known;
    bit          exp_dv;

    jpeg_idct_block_buf #(.WIDTH(16), .ADDR_W(6)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_i           (wr),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .wr_commit_i    (wr_commit),
        .wr_ready_o     (wr_ready),
        .rd_i           (rd),
        .rd_addr_i      (rd_addr),
        .rd_release_i   (rd_release),
        .rd_valid_o     (rd_valid),
        .rd_data_o      (rd_data),
        .rd_data_valid_o(rd_dv),
        .level_o        (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] map_addr(logic [5:0] a);
`ifdef JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN
        return {a[2:0], a[5:3]};
`else
        return a;
`endif
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        ccnt      = 0;
        exp_rd    = 16'h0;
        exp_known = 1'b1;
        exp_dv    = 1'b0;
        for (int i = 0; i < 64; i++) wm[i] = 1'b0;
    endtask

    task automatic chk_status(string tag);
        chk({tag, ".level"}, {30'd0, level}, ccnt);
        chk({tag, ".wr_ready"}, {31'd0, wr_ready}, {31'd0, ccnt != 2});
        chk({tag, ".rd_valid"}, {31'd0, rd_valid}, {31'd0, ccnt != 0});
        chk({tag, ".rd_dv"}, {31'd0, rd_dv}, {31'd0, exp_dv});
        if (exp_known)
            chk({tag, ".rd_data"}, {16'd0, rd_data}, {16'd0, exp_rd});
    endtask

    // apply current inputs for one clock, update model, check outputs
    task automatic cyc(string tag);
        bit wr_rdy;
        bit rd_vld;
        logic [5:0] m;
        wr_rdy = (ccnt != 2);
        rd_vld = (ccnt != 0);
        exp_dv = 1'b0;
        if (rd && rd_vld) begin
            m         = map_addr(rd_addr);
            exp_dv    = 1'b1;
            exp_known = cm[0][m];
            exp_rd    = cdat[0][m];
        end
        if (wr && wr_rdy) begin
            wdat[wr_addr] = wr_data;
            wm[wr_addr]   = 1'b1;
        end
        if (rd_release && rd_vld) begin
            for (int i = 0; i < 64; i++) begin
                cdat[0][i] = cdat[1][i];
                cm[0][i]   = cm[1][i];
            end
            ccnt--;
        end
        if (wr_commit && wr_rdy) begin
            for (int i = 0; i < 64; i++) begin
                cdat[ccnt][i] = wdat[i];
                cm[ccnt][i]   = wm[i];
                wm[i]         = 1'b0;
            end
            ccnt++;
        end
        @(posedge clk);
        #1;
        chk_status(tag);
    endtask

    task automatic step(string tag, bit w, logic [5:0] wa, logic [15:0] wd,
                        bit c, bit r, logic [5:0] ra, bit rel);
        wr = w; wr_addr = wa; wr_data = wd; wr_commit = c;
        rd = r; rd_addr = ra; rd_release = rel;
        cyc(tag);
        wr = 0; wr_commit = 0; rd = 0; rd_release = 0;
    endtask

    // write a full block data = base|addr, committing on the last write
    task automatic fill(string tag, logic [15:0] base, bit rel_last);
        for (int a = 0; a < 64; a++)
            step(tag, 1, 6'(a), base | 16'(a), a == 63, 0, 0, rel_last && a == 63);
    endtask

    initial begin
        rst = 0; wr = 0; wr_addr = 0; wr_data = 0; wr_commit = 0;
        rd = 0; rd_addr = 0; rd_release = 0;
        model_reset();
        #3;
        chk_status("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1;

        // single block, read addr 10
        fill("blk0", 16'h0000, 0);
        chk("blk0.level1", {30'd0, level}, 32'd1);
        step("rd10", 0, 0, 0, 0, 1, 6'd10, 0);
        chk("rd10.data", {16'd0, rd_data}, 32'd10);
        chk("rd10.dv", {31'd0, rd_dv}, 32'd1);
        step("rd10.idle", 0, 0, 0, 0, 0, 0, 0);
        chk("rd10.dv_drop", {31'd0, rd_dv}, 32'd0);
        step("rel0", 0, 0, 0, 0, 0, 0, 1);

        // two banks full, extra write ignored
        fill("blk1", 16'h0100, 0);
        fill("blk2", 16'h0200, 0);
        chk("full.wr_ready", {31'd0, wr_ready}, 32'd0);
        step("full.wr", 1, 6'd0, 16'hFFFF, 1, 0, 0, 0);
        step("full.rd0", 0, 0, 0, 0, 1, 6'd0, 0);
        chk("full.rd0.data", {16'd0, rd_data}, 32'h100);
        step("full.rel", 0, 0, 0, 0, 0, 0, 1);
        step("next.rd0", 0, 0, 0, 0, 1, 6'd0, 0);
        chk("next.rd0.data", {16'd0, rd_data}, 32'h200);

        // commit and release together at level 1
        fill("swap", 16'h0300, 1);
        chk("swap.level", {30'd0, level}, 32'd1);
        step("swap.rd0", 0, 0, 0, 0, 1, 6'd0, 0);
        chk("swap.rd0.data", {16'd0, rd_data}, 32'h300);

        // read with release, then read at level 0
        step("rdrel5", 0, 0, 0, 0, 1, 6'd5, 1);
        chk("rdrel5.data", {16'd0, rd_data}, 32'h305);
        step("rd_empty", 0, 0, 0, 0, 1, 6'd7, 0);
        chk("rd_empty.dv", {31'd0, rd_dv}, 32'd0);
        chk("rd_empty.hold", {16'd0, rd_data}, 32'h305);

        // row/column addressing
        step("tr.wr", 1, 6'h0B, 16'hABCD, 1, 0, 0, 0);
`ifdef JPEG_IDCT_BLOCK_BUF_TRANSPOSE_EN
        step("tr.rd", 0, 0, 0, 0, 1, 6'h19, 0);
`else
        step("tr.rd", 0, 0, 0, 0, 1, 6'h0B, 0);
`endif
        chk("tr.data", {16'd0, rd_data}, 32'hABCD);
        step("tr.rel", 0, 0, 0, 0, 0, 0, 1);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step("rand", $urandom_range(0, 3) != 0, 6'($urandom),
                 16'($urandom), $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, 6'($urandom),
                 $urandom_range(0, 39) == 0);

        // asynchronous reset after a commit and mid-write
        while (ccnt != 0) step("drain", 0, 0, 0, 0, 0, 0, 1);
        fill("pre", 16'h0400, 0);
        step("pre.rd", 0, 0, 0, 0, 1, 6'd9, 0);
        chk("pre.rd.data", {16'd0, rd_data}, 32'h409);
        for (int a = 0; a < 20; a++)
            step("pre.part", 1, 6'(a), 16'h0500 | 16'(a), 0, 0, 0, 0);
        #2 rst = 0;
        #1;
        model_reset();
        chk_status("arst");
        chk("arst.rd_data", {16'd0, rd_data}, 32'd0);
        #10 rst = 1;
        step("post", 0, 0, 0, 0, 1, 6'd0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
